uart_host_cmd_master: RTL and testbench
=======================================

Name: uart_host_cmd_master

Overview:
- Host-side initiator for the UART command protocol served by uart_bram_interface.
- Accepts write/read requests on a valid/ready port and serializes each as a 4-byte frame: SYNC 0xAA, CMD, ADDR, DATA.
- For reads, receives the single response byte on rx.
- Used as the on-chip/loopback driver for BRAM config and readback, and as the synthesizable bench master.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults).
- GAP_BITS, 2, idle bit periods inserted after every transmitted stop bit.
- TIMEOUT_BITS, 64, read-response timeout in bit periods (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE only; handshake = req_valid & req_ready
- req_write  in  1  1 = write (CMD 0x01), 0 = read (CMD 0x02)
- req_addr  in  8  BRAM address
- req_wdata  in  8  write data; ignored for reads (frame DATA byte = 0x00)
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  8  read byte, valid with rsp_valid; 0x00 for writes and errors
- rsp_err  out  1  valid with rsp_valid; 1 = read timeout
- busy  out  1  high from accept until the rsp_valid cycle, inclusive
- tx  out  1  UART line to responder, idle high
- rx  in  1  UART line from responder, idle high

Behaviour:
- Reset (async assert, sync deassert internally):
  - tx=1, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, all counters 0.
  - Reset mid-frame forces tx high immediately and abandons the frame; nothing is replayed.
- Request capture: on the handshake cycle, latch write flag, addr and data; the FSM leaves IDLE on the next edge.
- FSM states: IDLE -> SEND_SYNC -> SEND_CMD -> SEND_ADDR -> SEND_DATA -> (write: DONE | read: WAIT_RSP) -> DONE -> IDLE.
  - Each SEND_* state runs one byte through the TX engine, then GAP_BITS idle periods, before advancing.
  - DONE lasts one cycle and asserts rsp_valid.
- TX engine, per byte:
  - Start bit 0, data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; then GAP_BITS*CLKS_PER_BIT cycles high.
  - tx is registered.
  - Frame length = 4*(10+GAP_BITS)*CLKS_PER_BIT cycles.
- RX engine:
  - rx passes through a 2-FF synchronizer, sync output initialised to 1 on reset.
  - A falling edge arms the receiver; start bit is re-checked at CLKS_PER_BIT/2 and the byte is discarded if rx is high there (glitch).
  - Data bits are sampled at bit centres, LSB first. The stop bit is sampled at its centre; if low, framing error and the byte is discarded.
  - The RX engine runs continuously. A byte completing outside WAIT_RSP is dropped.
  - A byte completing in WAIT_RSP is loaded to rsp_rdata, with rsp_err=0, and the FSM moves to DONE.
- WAIT_RSP is entered after the DATA byte's gap completes. A response that starts during the gap is still captured if it completes in WAIT_RSP.
- Simultaneous req_valid with rsp_valid: not accepted that cycle (req_ready=0 in DONE); accepted the following cycle.
- rsp_rdata holds its value until the next rsp_valid.

Optional Feature:
- Macro: UART_HOST_TIMEOUT_EN.
- Defined:
  - WAIT_RSP runs a counter that resets on entry.
  - After TIMEOUT_BITS*CLKS_PER_BIT cycles with no completed byte, go to DONE with rsp_err=1 and rsp_rdata=0x00.
  - A byte completing on the same cycle as the timeout wins: data is returned with rsp_err=0.
- Not defined: WAIT_RSP waits indefinitely; rsp_err is tied 0; the counter is not synthesized.

Test Plan:
- Write addr 0x0A, data 0x55 -> tx carries 0xAA,0x01,0x0A,0x55 (decoded LSB-first at bit centres, 10+2 bit periods per byte); rsp_valid one pulse after final gap, rsp_err=0, rsp_rdata=0x00.
- Read addr 0x0A; bench responder returns 0x55 after 20 bit periods -> tx frame 0xAA,0x02,0x0A,0x00; rsp_valid with rsp_rdata=0x55, rsp_err=0; busy low the next cycle.
- Back-to-back: req_valid held high for two writes (0x01/0x11, 0x02/0x22) -> second accepted one cycle after the first rsp_valid; 8 bytes total on tx, no overlap.
- Stray byte 0x3C on rx while in IDLE, then read with response 0xC3 -> rsp_rdata=0xC3, not 0x3C. A 1-cycle low glitch on rx in WAIT_RSP is ignored.
- With UART_HOST_TIMEOUT_EN, read with no response -> rsp_valid after exactly 64*434 cycles in WAIT_RSP, rsp_err=1, rsp_rdata=0x00.
- Assert reset_n low mid-ADDR byte -> tx=1 and busy=0 in the same cycle (async). After release, a new write (0x05/0x99) produces a clean full frame.

Source files
------------

// File: rtl/uart_host_cmd_master.sv
// uart_host_cmd_master: host-side UART command initiator.
// Serializes each write/read request as a 4-byte frame: 0xAA, CMD, ADDR, DATA.
// A read then waits for one response byte on rx.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata request fields (CMD 0x01 write, 0x02 read)
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion, read data, timeout flag
//   busy                           accept through rsp_valid cycle
//   tx, rx                         UART lines, idle high
// Optional: define UART_HOST_TIMEOUT_EN to bound WAIT_RSP by TIMEOUT_BITS bit periods.
module uart_host_cmd_master #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int GAP_BITS     = 2,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       tx,
  input  logic       rx
);
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int NB   = 10 + GAP_BITS;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(NB);

  if (CPB < 2 || TIMEOUT_BITS < 1 || GAP_BITS < 0) begin : g_bad_cfg
    $error("uart_host_cmd_master: invalid baud/timeout configuration");
  end

  typedef enum logic [2:0] {IDLE, SEND_SYNC, SEND_CMD, SEND_ADDR, SEND_DATA, WAIT_RSP, DONE} state_t;
  state_t state;

  // async assert, sync release of the internal reset
  logic [1:0] rst_q;
  logic       rst_s_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_s_n = rst_q[1];

  // RX engine: free-running, emits a one-cycle rx_done with a good byte
  logic [1:0]    rx_sync;
  logic          rs, rs_d, rx_act, rx_done;
  logic [7:0]    rx_sh, rx_byte;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  assign rs = rx_sync[1];
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      rx_sync <= 2'b11;
      rs_d    <= 1'b1;
      rx_act  <= 1'b0;
      rx_done <= 1'b0;
      rx_sh   <= '0;
      rx_byte <= '0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rs_d    <= rs;
      rx_done <= 1'b0;
      if (!rx_act) begin
        rx_act <= rs_d & ~rs;
        rx_cnt <= '0;
        rx_bit <= '0;
      end else if (rx_cnt != ((rx_bit == 4'd0) ? CW'(HALF - 1) : CW'(CPB - 1))) begin
        rx_cnt <= rx_cnt + 1'b1;
      end else begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0) rx_act <= ~rs;
        else if (rx_bit != 4'd9) rx_sh <= {rs, rx_sh[7:1]};
        else begin
          rx_act  <= 1'b0;
          rx_done <= rs;
          rx_byte <= rx_sh;
        end
      end
    end

  // TX shifter holds the bits after the start bit: data LSB first, stop, gap
  logic          wr;
  logic [7:0]    addr, data, next_byte;
  logic [NB-2:0] sh;
  logic [CW-1:0] tx_cnt;
  logic [BW-1:0] tx_bit;
  always_comb next_byte = state == SEND_SYNC ? (wr ? 8'h01 : 8'h02) : state == SEND_CMD ? addr : data;

`ifdef UART_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS * CPB);
  logic [TW-1:0] to_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      tx        <= 1'b1;
      wr        <= 1'b0;
      addr      <= '0;
      data      <= '0;
      sh        <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
`ifdef UART_HOST_TIMEOUT_EN
      rsp_err   <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE:
          if (req_valid) begin
            wr        <= req_write;
            addr      <= req_addr;
            data      <= req_write ? req_wdata : 8'h00;
            sh        <= {{GAP_BITS{1'b1}}, 1'b1, 8'hAA};
            tx        <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND_SYNC;
          end
        SEND_SYNC, SEND_CMD, SEND_ADDR, SEND_DATA:
          if (tx_cnt != CW'(CPB - 1)) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt <= '0;
            if (tx_bit != BW'(NB - 1)) begin
              tx     <= sh[0];
              sh     <= sh >> 1;
              tx_bit <= tx_bit + 1'b1;
            end else begin
              tx_bit <= '0;
              if (state != SEND_DATA) begin
                tx    <= 1'b0;
                sh    <= {{GAP_BITS{1'b1}}, 1'b1, next_byte};
                state <= state_t'(state + 3'd1);
              end else begin
                state     <= wr ? DONE : WAIT_RSP;
                rsp_valid <= wr;
                if (wr) rsp_rdata <= 8'h00;
`ifdef UART_HOST_TIMEOUT_EN
                if (wr) rsp_err <= 1'b0;
                to_cnt <= '0;
`endif
              end
            end
          end
        WAIT_RSP:
          // a byte completing on the timeout cycle takes priority
          if (rx_done) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_byte;
`ifdef UART_HOST_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (to_cnt == TW'(TIMEOUT_BITS * CPB - 1)) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_host_cmd_master.sv
// tb_uart_host_cmd_master: self-checking bench for uart_host_cmd_master (16 clocks per bit).
module tb_uart_host_cmd_master;
  localparam int CPB = 16;
  localparam int FRAME = 48 * CPB;

  logic       clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, req_write = 1'b0, rx = 1'b1;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err, busy, tx;
  logic [7:0] rsp_rdata;

  int total = 0, bad = 0, rst_cnt = 0;
  logic [7:0] mon_q[$];
  longint     mon_t[$];
  logic [7:0] last_rdata = 8'h00;

  typedef struct {
    bit         w;
    logic [7:0] a, d;
    int         rstart;
    logic [7:0] rb;
    bit         glitch;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;
  always @(negedge reset_n) rst_cnt++;

  uart_host_cmd_master #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .GAP_BITS(2), .TIMEOUT_BITS(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .tx(tx), .rx(rx)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // tx decoder: samples near bit centres, drops bytes cut by a reset
  initial begin : mon
    logic [7:0] b;
    logic       st, sp;
    longint     t;
    int         r0;
    forever begin
      @(negedge tx);
      t  = $time;
      r0 = rst_cnt;
      repeat (CPB / 2) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      sp = tx;
      if (rst_cnt == r0) begin
        chk("tx_start_bit", st, 0);
        chk("tx_stop_bit", sp, 1);
        mon_q.push_back(b);
        mon_t.push_back(t);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic respond(input int start, input logic [7:0] b);
    repeat (start * CPB - 1) @(negedge clk);
    send_byte(b);
  endtask

  task automatic glitch_at(input int start);
    repeat (start * CPB - 1) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
  endtask

  // one request; rstart = response start in bit periods after accept (-1: none)
  task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d, input int rstart,
                        input logic [7:0] rb, input bit glitch, input logic [7:0] exp_rd, input bit exp_err);
    longint t0;
    int n;
    logic [7:0] exp_b[4];
    chk("rdata_hold", rsp_rdata, last_rdata);
    mon_q.delete();
    mon_t.delete();
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", req_ready, 1);
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", req_ready, 0);
    if (!w && rstart >= 0) fork respond(rstart, rb); join_none
    if (glitch) fork glitch_at(50); join_none
    n = 1;
    while (!rsp_valid && n < 200 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    chk("busy_in_done", busy, 1);
    if (w) chk("write_latency", n, FRAME + 1);
    else if (exp_err) chk("timeout_latency", n, FRAME + 64 * CPB + 1);
    else chk("read_in_window", n > (rstart + 9) * CPB && n <= (rstart + 11) * CPB, 1);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("busy_clear", busy, 0);
    chk("ready_back", req_ready, 1);
    last_rdata = exp_rd;
    exp_b = '{8'hAA, w ? 8'h01 : 8'h02, a, w ? d : 8'h00};
    chk("frame_len", mon_q.size(), 4);
    for (int i = 0; i < 4 && i < mon_q.size(); i++) chk("frame_byte", mon_q[i], exp_b[i]);
    if (mon_q.size() == 4) begin
      chk("frame_start", mon_t[0] - t0, 0);
      for (int i = 1; i < 4; i++) chk("byte_spacing", mon_t[i] - mon_t[i - 1], 12 * CPB * 10);
    end
  endtask

  initial begin
    longint t0, t_first;
    int n;
    logic [7:0] exp8[8];
    bit w;
    logic [7:0] a, d, rb;
    int rs;

    tbl[0] = '{1'b1, 8'h0A, 8'h55, -1, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h0A, 8'hFF, 68, 8'h55, 1'b0, 8'h55};
    tbl[2] = '{1'b0, 8'hF0, 8'h12, 47, 8'hA5, 1'b0, 8'hA5};
    tbl[3] = '{1'b0, 8'h33, 8'h00, 60, 8'h5A, 1'b1, 8'h5A};
    tbl[4] = '{1'b1, 8'hFF, 8'h00, -1, 8'h00, 1'b0, 8'h00};

    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_err", rsp_err, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (tbl[i])
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rstart, tbl[i].rb, tbl[i].glitch, tbl[i].exp_rd, 1'b0);

    // back-to-back writes with req_valid held
    mon_q.delete();
    mon_t.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h01; req_wdata = 8'h11;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    req_addr = 8'h02; req_wdata = 8'h22;
    n = 1;
    while (!rsp_valid && n < 200 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", n, FRAME + 1);
    chk("b2b_not_ready_in_done", req_ready, 0);
    @(negedge clk);
    chk("b2b_ready_after_done", req_ready, 1);
    chk("b2b_pulse", rsp_valid, 0);
    @(negedge clk);
    chk("b2b_second_accepted", busy, 1);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 200 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_latency", n, FRAME + 1);
    @(negedge clk);
    exp8 = '{8'hAA, 8'h01, 8'h01, 8'h11, 8'hAA, 8'h01, 8'h02, 8'h22};
    chk("b2b_len", mon_q.size(), 8);
    for (int i = 0; i < 8 && i < mon_q.size(); i++) chk("b2b_byte", mon_q[i], exp8[i]);
    if (mon_q.size() == 8) begin
      chk("b2b_second_start", mon_t[4] - t0, (FRAME + 2) * 10);
      chk("b2b_no_overlap", mon_t[4] - mon_t[3], (12 * CPB + 2) * 10);
    end
    last_rdata = 8'h00;

    // stray byte while idle must not leak into the next read
    send_byte(8'h3C);
    repeat (2 * CPB) @(negedge clk);
    do_req(1'b0, 8'h0A, 8'h00, 60, 8'hC3, 1'b0, 8'hC3, 1'b0);

    for (int k = 0; k < 8; k++) begin
      w  = 1'($urandom);
      a  = 8'($urandom);
      d  = 8'($urandom);
      rb = 8'($urandom);
      rs = int'($urandom_range(47, 70));
      do_req(w, a, d, w ? -1 : rs, rb, 1'b0, w ? 8'h00 : rb, 1'b0);
    end

`ifdef UART_HOST_TIMEOUT_EN
    do_req(1'b0, 8'h44, 8'h00, -1, 8'h00, 1'b0, 8'h00, 1'b1);
`endif

    // reset during the ADDR start bit
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h0A; req_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (24 * CPB + 2) @(negedge clk);
    chk("addr_start_low", tx, 0);
    chk("busy_mid_frame", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (14 * CPB) @(negedge clk);
    last_rdata = 8'h00;
    do_req(1'b1, 8'h05, 8'h99, -1, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
